// File: rtl/startup_sequencer.sv
// Startup sequencer: waits for a stable synchronized PLL lock plus a user request,
// settles, then emits STARTCLK pulses that release GWE and GSR_N before reporting DONE.
module startup_sequencer #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int DIV            = 4,
    parameter int START_PULSES   = 8,
    parameter bit RELOCK_RESTART = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK,
    input  logic       USRSTART,
    output logic       STARTCLK,
    output logic       GWE,
    output logic       GSR_N,
    output logic       DONE,
    output logic [1:0] STATE
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DIV + 1);
    localparam int PW = $clog2(START_PULSES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
    localparam logic [PW-1:0] GWE_PRE     = PW'(START_PULSES - 2);
    localparam logic [PW-1:0] GSR_PRE     = PW'(START_PULSES - 1);
    localparam logic [PW-1:0] PULSES_ALL  = PW'(START_PULSES);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_CLKGEN    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_lock_m;
    logic          r_lock_s;
    logic [SW-1:0] r_settle_cnt;
    logic [DW-1:0] r_div_cnt;
    logic [PW-1:0] r_pulse_cnt;
    logic          r_startclk;
    logic          r_gwe;
    logic          r_gsr_n;
    logic          r_done;

    // LOCK comes from the PLL domain; two flops before the FSM may look at it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= LOCK;
            r_lock_s <= r_lock_m;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_WAIT_LOCK;
            r_settle_cnt <= '0;
            r_div_cnt    <= '0;
            r_pulse_cnt  <= '0;
            r_startclk   <= 1'b0;
            r_gwe        <= 1'b0;
            r_gsr_n      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    r_settle_cnt <= '0;
                    r_div_cnt    <= '0;
                    r_pulse_cnt  <= '0;
                    if (r_lock_s && USRSTART) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!r_lock_s) begin
                        r_state      <= S_WAIT_LOCK;
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state      <= S_CLKGEN;
                        r_settle_cnt <= '0;
                        r_div_cnt    <= '0;
                        r_pulse_cnt  <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_CLKGEN: begin
                    // Abort is checked first so it wins over the final DONE step.
                    if (!r_lock_s) begin
                        r_state     <= S_WAIT_LOCK;
                        r_div_cnt   <= '0;
                        r_pulse_cnt <= '0;
                        r_startclk  <= 1'b0;
                        r_gwe       <= 1'b0;
                        r_gsr_n     <= 1'b0;
                    end else if (r_div_cnt != DIV_LAST) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= '0;
                        if (r_startclk) begin
                            r_startclk <= 1'b0;
                            if (r_pulse_cnt == PULSES_ALL) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_startclk  <= 1'b1;
                            r_pulse_cnt <= r_pulse_cnt + 1'b1;
                            if (r_pulse_cnt == GWE_PRE) r_gwe <= 1'b1;
                            if (r_pulse_cnt == GSR_PRE) r_gsr_n <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!r_lock_s && RELOCK_RESTART) begin
                        r_state <= S_WAIT_LOCK;
                        r_gwe   <= 1'b0;
                        r_gsr_n <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_WAIT_LOCK;
            endcase
        end
    end

    assign STARTCLK = r_startclk;
    assign GWE      = r_gwe;
    assign GSR_N    = r_gsr_n;
    assign DONE     = r_done;
    assign STATE    = r_state;
endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: two instances (relock restart on/off) share stimulus and
// are compared every cycle against a timeline model of the startup sequence.
module tb_startup_sequencer;
    localparam int S = 16;
    localparam int D = 2;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       usr = 1'b0;
    logic       sclk_a, gwe_a, gsr_a, done_a;
    logic [1:0] st_a;
    logic       sclk_b, gwe_b, gsr_b, done_b;
    logic [1:0] st_b;

    logic [5:0] exp_q_a[$];
    logic [5:0] exp_q_b[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode[2] = '{0, 0};
    int mark[2] = '{0, 0};
    logic pipe0 = 1'b0;
    logic pipe1 = 1'b0;

    always #5 clk = ~clk;

    startup_sequencer #(.SETTLE_CYCLES(S), .DIV(D), .START_PULSES(P), .RELOCK_RESTART(1'b1)) u_dut_a (
        .CLK(clk), .RST(rst), .LOCK(lock), .USRSTART(usr),
        .STARTCLK(sclk_a), .GWE(gwe_a), .GSR_N(gsr_a), .DONE(done_a), .STATE(st_a)
    );

    startup_sequencer #(.SETTLE_CYCLES(S), .DIV(D), .START_PULSES(P), .RELOCK_RESTART(1'b0)) u_dut_b (
        .CLK(clk), .RST(rst), .LOCK(lock), .USRSTART(usr),
        .STARTCLK(sclk_b), .GWE(gwe_b), .GSR_N(gsr_b), .DONE(done_b), .STATE(st_b)
    );

    // Output vector {STARTCLK, GWE, GSR_N, DONE, STATE} from phase and time since phase entry.
    function automatic logic [5:0] expect_out(input int md, input int t);
        int ph;
        int k;
        logic [5:0] v;
        v = 6'b0;
        case (md)
            1: v = 6'b000001;
            2: begin
                ph = t / D;
                k  = (ph + 1) / 2;
                v  = {(ph % 2) == 1, k >= P - 1, k >= P, 1'b0, 2'd2};
            end
            3: v = 6'b011111;
            default: v = 6'b0;
        endcase
        return v;
    endfunction

    // Reference timeline: lock is seen two edges late, phases advance on elapsed time.
    always @(posedge clk) begin
        logic ls;
        cyc++;
        if (rst) begin
            pipe0 = 1'b0;
            pipe1 = 1'b0;
            mode  = '{0, 0};
            mark  = '{0, 0};
        end else begin
            ls    = pipe1;
            pipe1 = pipe0;
            pipe0 = lock;
            for (int i = 0; i < 2; i++) begin
                case (mode[i])
                    0: if (ls && usr) begin mode[i] = 1; mark[i] = cyc; end
                    1: begin
                        if (!ls) mode[i] = 0;
                        else if (cyc - mark[i] == S) begin mode[i] = 2; mark[i] = cyc; end
                    end
                    2: begin
                        if (!ls) mode[i] = 0;
                        else if (cyc - mark[i] == 2 * D * P) mode[i] = 3;
                    end
                    default: if (!ls && i == 0) mode[i] = 0;
                endcase
            end
        end
        exp_q_a.push_back(expect_out(mode[0], cyc - mark[0]));
        exp_q_b.push_back(expect_out(mode[1], cyc - mark[1]));
    end

    always @(negedge clk) begin
        logic [5:0] exp_v;
        logic [5:0] got;
        if (exp_q_a.size() > 0) begin
            exp_v = exp_q_a.pop_front();
            got   = {sclk_a, gwe_a, gsr_a, done_a, st_a};
            total++;
            if (got !== exp_v) begin
                bad++;
                if (bad <= 20) $display("FAIL inst_a cyc=%0d got=%b exp=%b", cyc, got, exp_v);
            end
        end
        if (exp_q_b.size() > 0) begin
            exp_v = exp_q_b.pop_front();
            got   = {sclk_b, gwe_b, gsr_b, done_b, st_b};
            total++;
            if (got !== exp_v) begin
                bad++;
                if (bad <= 20) $display("FAIL inst_b cyc=%0d got=%b exp=%b", cyc, got, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int rises;
        int done_at;
        logic prev;

        // Clean sequence: count pulses and the DONE cycle relative to reset release.
        lock = 1'b1;
        usr  = 1'b1;
        do_reset();
        rises   = 0;
        done_at = -1;
        prev    = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (done_a && done_at < 0) done_at = i;
        end
        check("pulse_count", rises, P);
        check("done_cycle", done_at, 3 + S + 2 * D * P);

        // Lock glitch during settle.
        do_reset();
        tick(3 + 10);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(60);

        // Lock loss after the second STARTCLK rise, then rerun.
        do_reset();
        tick(3 + S + 3 * D);
        lock = 1'b0;
        tick(6);
        lock = 1'b1;
        tick(70);

        // Lock loss in DONE: instance a restarts, instance b stays done.
        do_reset();
        tick(50);
        lock = 1'b0;
        tick(10);
        lock = 1'b1;
        tick(60);
        lock = 1'b0;
        tick(100);
        lock = 1'b1;
        tick(5);

        // No user request: nothing moves until it arrives.
        usr = 1'b0;
        do_reset();
        tick(50);
        usr = 1'b1;
        tick(60);

        // Reset between pulse 3 and pulse 4.
        do_reset();
        tick(3 + S + 5 * D + 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(60);

        // Random segments of lock, request and occasional reset.
        for (int seg = 0; seg < 60; seg++) begin
            lock = ($urandom_range(0, 7) != 0);
            usr  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick($urandom_range(1, 50));
        end

        tick(3);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
